// File: rtl/matrix_scroll_sequencer.sv
// Scroll sequencer for an 8x8 LED matrix serializer: queues digit codes and
// steps a cur/next digit pair through shifts 0..7, one paced frame per shift.
module matrix_scroll_sequencer #(
    parameter int DEPTH     = 4,
    parameter int DIGIT_W   = 4,
    parameter int FRAME_GAP = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic               pause,
    output logic               frame_req,
    input  logic               frame_ack,
    input  logic               frame_done,
    output logic [DIGIT_W-1:0] cur_digit,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               cur_blank,
    output logic               next_blank,
    output logic [2:0]         shift,
    output logic               active
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

    state_t               r_state, w_state_nx;
    logic [DIGIT_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wr, r_rd;
    logic [CW-1:0]        r_cnt;
    logic [GW-1:0]        r_gap, w_gap_nx;
    logic [DIGIT_W-1:0]   r_cur, r_next, w_cur_nx, w_next_nx;
    logic                 r_cb, r_nb, w_cb_nx, w_nb_nx;
    logic [2:0]           r_shift, w_shift_nx;
    logic                 w_full, w_empty, w_push, w_pop;
    logic [DIGIT_W-1:0]   w_head;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_push  = digit_valid && !w_full;
    assign w_head  = r_mem[r_rd];

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= digit_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_cur   <= '0;
            r_next  <= '0;
            r_cb    <= 1'b1;
            r_nb    <= 1'b1;
            r_shift <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_gap   <= w_gap_nx;
            r_cur   <= w_cur_nx;
            r_next  <= w_next_nx;
            r_cb    <= w_cb_nx;
            r_nb    <= w_nb_nx;
            r_shift <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gap_nx   = r_gap;
        w_cur_nx   = r_cur;
        w_next_nx  = r_next;
        w_cb_nx    = r_cb;
        w_nb_nx    = r_nb;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_next_nx  = w_head;
                    w_nb_nx    = 1'b0;
                    w_cb_nx    = 1'b1;
                    w_shift_nx = 3'd0;
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (frame_ack) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (frame_done) begin
                    w_gap_nx   = GW'(FRAME_GAP - 1);
                    w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (r_gap != '0) begin
                        w_gap_nx = r_gap - 1'b1;
                    end else if (r_shift != 3'd7) begin
                        w_shift_nx = r_shift + 3'd1;
                        w_state_nx = S_REQ;
                    end else begin
                        // End of a step: incoming digit becomes outgoing one.
                        w_cur_nx   = r_next;
                        w_cb_nx    = r_nb;
                        w_shift_nx = 3'd0;
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_next_nx = w_head;
                            w_nb_nx   = 1'b0;
                        end else begin
                            w_nb_nx   = 1'b1;
                        end
                        w_state_nx = (r_nb && w_empty) ? S_IDLE : S_REQ;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign digit_ready = !w_full;
    assign frame_req   = (r_state == S_REQ);
    assign active      = (r_state != S_IDLE);
    assign cur_digit   = r_cur;
    assign next_digit  = r_next;
    assign cur_blank   = r_cb;
    assign next_blank  = r_nb;
    assign shift       = r_shift;
endmodule

// File: tb/tb_matrix_scroll_sequencer.sv
// Bench for matrix_scroll_sequencer: serializer model plus a step/frame
// reference built from the digit list, with randomized latencies and digits.
module tb_matrix_scroll_sequencer;
    localparam int DEPTH = 4;
    localparam int DW    = 4;
    localparam int FG    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] digit_in;
    logic          digit_valid, digit_ready, pause;
    logic          frame_req, frame_ack, frame_done;
    logic [DW-1:0] cur_digit, next_digit;
    logic          cur_blank, next_blank, active;
    logic [2:0]    shift;

    int n_vec = 0;
    int n_err = 0;

    matrix_scroll_sequencer #(.DEPTH(DEPTH), .DIGIT_W(DW), .FRAME_GAP(FG)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .pause(pause), .frame_req(frame_req),
        .frame_ack(frame_ack), .frame_done(frame_done), .cur_digit(cur_digit),
        .next_digit(next_digit), .cur_blank(cur_blank), .next_blank(next_blank),
        .shift(shift), .active(active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        digit_valid = 0; digit_in = '0; pause = 0; frame_ack = 0; frame_done = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic push_list(input logic [DW-1:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            bit acc;
            int guard;
            guard = 0;
            digit_valid = 1;
            digit_in    = q[i];
            do begin
                acc = digit_ready;
                tick();
                guard++;
            end while (!acc && guard < 20000);
            digit_valid = 0;
        end
    endtask

    // Serializer model: waits for a request, acks after ack_lat cycles,
    // reports done done_lat cycles later. wait_cnt is the idle time before req.
    task automatic do_frame(input int ack_lat, input int done_lat, input int pause_gap,
                            input bit pause_rw,
                            output logic [DW-1:0] c, output logic [DW-1:0] n,
                            output logic cb, output logic nb, output logic [2:0] sh,
                            output int wait_cnt, output bit to, output bit unstable);
        to = 0; unstable = 0; wait_cnt = 0;
        c = '0; n = '0; cb = 0; nb = 0; sh = '0;
        while (!frame_req && wait_cnt < 3000) begin
            pause = (wait_cnt < pause_gap);
            tick();
            wait_cnt++;
        end
        pause = 0;
        if (!frame_req) begin
            to = 1;
            return;
        end
        c = cur_digit; n = next_digit; cb = cur_blank; nb = next_blank; sh = shift;
        if (pause_rw) pause = 1;
        for (int i = 0; i < ack_lat; i++) begin
            tick();
            if (!frame_req || cur_digit !== c || next_digit !== n || cur_blank !== cb ||
                next_blank !== nb || shift !== sh) unstable = 1;
        end
        frame_ack = 1;
        tick();
        frame_ack = 0;
        if (frame_req) unstable = 1;
        for (int i = 0; i < done_lat; i++) begin
            tick();
            if (frame_req) unstable = 1;
        end
        frame_done = 1;
        pause = 0;
        tick();
        frame_done = 0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] q[$];
        int guard;
        reset = 1; digit_valid = 0; digit_in = '0; pause = 0; frame_ack = 0; frame_done = 0;
        tick();
        n_vec++;
        if (frame_req !== 0 || active !== 0 || shift !== 0 || cur_blank !== 1 ||
            next_blank !== 1 || cur_digit !== 0 || next_digit !== 0 || digit_ready !== 1) begin
            n_err++;
            $display("FAIL reset_init: req=%b act=%b sh=%0d cb=%b nb=%b cur=%0h nxt=%0h rdy=%b, want 0 0 0 1 1 0 0 1",
                     frame_req, active, shift, cur_blank, next_blank, cur_digit, next_digit, digit_ready);
        end
        reset = 0;
        tick();
        q = {4'd3, 4'd4, 4'd5, 4'd6};
        push_list(q);
        guard = 0;
        while (!frame_req && guard < 100) begin tick(); guard++; end
        frame_ack = 1; tick(); frame_ack = 0;
        tick(); tick();
        n_vec++;
        if (frame_req !== 0 || active !== 1 || digit_ready !== 1 || next_digit !== 4'd3) begin
            n_err++;
            $display("FAIL reset_prewait: req=%b act=%b rdy=%b nxt=%0h, want 0 1 1 3",
                     frame_req, active, digit_ready, next_digit);
        end
        #2 reset = 1;
        #1;
        n_vec++;
        if (frame_req !== 0 || active !== 0 || shift !== 0 || cur_blank !== 1 ||
            next_blank !== 1 || cur_digit !== 0 || next_digit !== 0 || digit_ready !== 1) begin
            n_err++;
            $display("FAIL reset_async: req=%b act=%b sh=%0d cb=%b nb=%b cur=%0h nxt=%0h rdy=%b, want 0 0 0 1 1 0 0 1",
                     frame_req, active, shift, cur_blank, next_blank, cur_digit, next_digit, digit_ready);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (active !== 0 || frame_req !== 0) begin
            n_err++;
            $display("FAIL reset_qempty: act=%b req=%b, want 0 0", active, frame_req);
        end
    endtask

    task automatic test_scroll(input string tag, input logic [DW-1:0] d[$],
                               input int ack_lat, input int done_lat, input bit rnd);
        int nsteps;
        bit abort;
        nsteps = d.size() + 1;
        abort  = 0;
        fork
            push_list(d);
            begin
                for (int k = 0; k < nsteps && !abort; k++) begin
                    for (int s = 0; s < 8 && !abort; s++) begin
                        logic [DW-1:0] c, n, ec, en;
                        logic cb, nb, ecb, enb;
                        logic [2:0] sh;
                        int wc, al, dl;
                        bit to, un, ok;
                        al  = rnd ? int'($urandom_range(0, 3)) : ack_lat;
                        dl  = rnd ? int'($urandom_range(1, 40)) : done_lat;
                        ecb = (k == 0);
                        enb = (k == nsteps - 1);
                        ec  = (k == 0) ? '0 : d[k-1];
                        en  = (k == nsteps - 1) ? '0 : d[k];
                        do_frame(al, dl, 0, 0, c, n, cb, nb, sh, wc, to, un);
                        ok = !to && !un && sh === 3'(s) && cb === ecb && nb === enb &&
                             (ecb || c === ec) && (enb || n === en);
                        n_vec++;
                        if (!ok) begin
                            n_err++;
                            $display("FAIL %s frame k=%0d s=%0d: got cur=%0h/%b nxt=%0h/%b sh=%0d unst=%b to=%b, want cur=%0h/%b nxt=%0h/%b sh=%0d",
                                     tag, k, s, c, cb, n, nb, sh, un, to, ec, ecb, en, enb, s);
                            if (to) abort = 1;
                        end
                        if (k != 0 || s != 0) begin
                            n_vec++;
                            if (wc !== FG) begin
                                n_err++;
                                $display("FAIL %s gap k=%0d s=%0d: got %0d cycles, want %0d", tag, k, s, wc, FG);
                            end
                        end
                    end
                end
            end
        join
        for (int i = 0; i < FG + 4; i++) tick();
        n_vec++;
        if (active !== 0 || frame_req !== 0 || digit_ready !== 1) begin
            n_err++;
            $display("FAIL %s idle_end: act=%b req=%b rdy=%b, want 0 0 1", tag, active, frame_req, digit_ready);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] q[$];
        int acc, guard;
        logic last_rdy;
        do_reset();
        q = {4'd9};
        push_list(q);
        guard = 0;
        while (!frame_req && guard < 100) begin tick(); guard++; end
        acc = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            digit_valid = 1;
            digit_in    = DW'(i + 2);
            if (digit_ready) acc++;
            tick();
        end
        digit_valid = 0;
        n_vec++;
        if (acc !== DEPTH || digit_ready !== 0) begin
            n_err++;
            $display("FAIL fill_full: accepted=%0d rdy=%b, want %0d 0", acc, digit_ready, DEPTH);
        end
        for (int f = 0; f < 8; f++) begin
            logic [DW-1:0] c, n;
            logic cb, nb;
            logic [2:0] sh;
            int wc;
            bit to, un;
            do_frame(0, 2, 0, 0, c, n, cb, nb, sh, wc, to, un);
        end
        last_rdy = digit_ready;
        guard = 0;
        while (!frame_req && guard < 200) begin
            last_rdy = digit_ready;
            tick();
            guard++;
        end
        n_vec++;
        if (last_rdy !== 0 || digit_ready !== 1 || frame_req !== 1 || shift !== 0 ||
            cur_digit !== 4'd9 || cur_blank !== 0 || next_digit !== 4'd2 || next_blank !== 0) begin
            n_err++;
            $display("FAIL fill_pop: rdy_before=%b rdy=%b req=%b sh=%0d cur=%0h/%b nxt=%0h/%b, want 0 1 1 0 9/0 2/0",
                     last_rdy, digit_ready, frame_req, shift, cur_digit, cur_blank, next_digit, next_blank);
        end
        do_reset();
    endtask

    task automatic test_pause();
        logic [DW-1:0] q[$];
        logic [DW-1:0] c, n;
        logic cb, nb;
        logic [2:0] sh;
        int wc;
        bit to, un;
        do_reset();
        q = {4'd7};
        push_list(q);
        do_frame(1, 10, 0, 0, c, n, cb, nb, sh, wc, to, un);
        do_frame(2, 10, 0, 1, c, n, cb, nb, sh, wc, to, un);
        n_vec++;
        if (to || un || sh !== 3'd1) begin
            n_err++;
            $display("FAIL pause_rw_frame: to=%b unst=%b sh=%0d, want 0 0 1", to, un, sh);
        end
        do_frame(1, 10, 0, 0, c, n, cb, nb, sh, wc, to, un);
        n_vec++;
        if (wc !== FG || sh !== 3'd2) begin
            n_err++;
            $display("FAIL pause_rw_gap: got %0d cycles sh=%0d, want %0d sh=2", wc, sh, FG);
        end
        do_frame(1, 10, 50, 0, c, n, cb, nb, sh, wc, to, un);
        n_vec++;
        if (wc !== FG + 50 || sh !== 3'd3 || to) begin
            n_err++;
            $display("FAIL pause_gap: got %0d cycles sh=%0d, want %0d sh=3", wc, sh, FG + 50);
        end
        do_reset();
    endtask

    task automatic test_spurious();
        logic [DW-1:0] q[$];
        logic [DW-1:0] c, n;
        logic cb, nb;
        logic [2:0] sh;
        int wc, guard;
        bit to, un;
        do_reset();
        q = {4'd3};
        push_list(q);
        do_frame(1, 5, 0, 0, c, n, cb, nb, sh, wc, to, un);
        guard = 0;
        while (!frame_req && guard < 100) begin tick(); guard++; end
        frame_done = 1; tick(); frame_done = 0;
        tick();
        n_vec++;
        if (frame_req !== 1 || shift !== 3'd1 || active !== 1) begin
            n_err++;
            $display("FAIL spur_done_in_req: req=%b sh=%0d act=%b, want 1 1 1", frame_req, shift, active);
        end
        frame_ack = 1; tick(); frame_ack = 0;
        frame_ack = 1; tick(); frame_ack = 0;
        tick(); tick();
        n_vec++;
        if (frame_req !== 0 || shift !== 3'd1 || active !== 1) begin
            n_err++;
            $display("FAIL spur_ack_in_wait: req=%b sh=%0d act=%b, want 0 1 1", frame_req, shift, active);
        end
        frame_done = 1; tick(); frame_done = 0;
        wc = 0;
        while (!frame_req && wc < 200) begin tick(); wc++; end
        n_vec++;
        if (wc !== FG || shift !== 3'd2) begin
            n_err++;
            $display("FAIL spur_resume: got gap=%0d sh=%0d, want %0d sh=2", wc, shift, FG);
        end
        do_reset();
    endtask

    initial begin
        logic [DW-1:0] q[$];
        test_reset();
        do_reset();
        q = {4'd5};
        test_scroll("single5", q, 1, 100, 0);
        q = {4'd1, 4'd0, 4'd1};
        test_scroll("back_to_back", q, 1, 20, 0);
        for (int it = 0; it < 3; it++) begin
            int nd;
            nd = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < nd; i++) q.push_back(DW'($urandom_range(0, 15)));
            test_scroll($sformatf("rand%0d", it), q, 0, 0, 1);
        end
        test_fill();
        test_pause();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
